// File: rtl/fht_pkg.sv
// Shared widths, state type and constants for the FHT bank unloader.
// Width defines fall back to a 256-word bank of 16-bit samples when not set by the build.
`ifndef A_BIT
`define A_BIT 8
`endif
`ifndef D_BIT
`define D_BIT 16
`endif
`ifndef BANK_SIZE
`define BANK_SIZE (2**`A_BIT)
`endif

package fht_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        STREAM,
        DONE
    } state_t;

    localparam int N_SAMPLES = 4 * `BANK_SIZE;
    localparam int SCALE_SH  = $clog2(N_SAMPLES);

    // Address of the final bank row; the FSM finishes after streaming it.
    localparam logic [`A_BIT-1:0] A_LAST = `A_BIT'(`BANK_SIZE - 1);

endpackage

// File: rtl/fht_unload_buf.sv
// Four-word capture register holding one row read from banks 0..3.
// The word selected by sel is presented combinationally on dout.
module fht_unload_buf
    import fht_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [1:0]        sel,
    input  logic [`D_BIT-1:0] din_0,
    input  logic [`D_BIT-1:0] din_1,
    input  logic [`D_BIT-1:0] din_2,
    input  logic [`D_BIT-1:0] din_3,
    output logic [`D_BIT-1:0] dout
);

    logic [`D_BIT-1:0] words [4];

    // NOTE: this small buffer is reset (unlike a RAM) because the sample
    // output must read zero while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) words[i] <= '0;
        end else if (load) begin
            words[0] <= din_0;
            words[1] <= din_1;
            words[2] <= din_2;
            words[3] <= din_3;
        end
    end

    assign dout = words[sel];

endmodule

// File: rtl/fht_unload.sv
// Unloads four FHT result banks as one natural-order sample stream with valid/ready.
// Define FHT_UNLOAD_SCALE_EN to divide each output sample by the transform length.
module fht_unload
    import fht_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iSTART,
    output logic [`A_BIT-1:0] oADDR_RD,
    output logic              oRE,
    input  logic [`D_BIT-1:0] iDATA_0,
    input  logic [`D_BIT-1:0] iDATA_1,
    input  logic [`D_BIT-1:0] iDATA_2,
    input  logic [`D_BIT-1:0] iDATA_3,
    output logic [`D_BIT-1:0] oDATA,
    output logic              oVALID,
    input  logic              iREADY,
    output logic              oRDY,
    output logic              oDONE
);

    state_t            state;
    logic [`A_BIT-1:0] a;
    logic [1:0]        w;
    logic [`D_BIT-1:0] buf_word;

    // NOTE: every register here uses <= so all next-state values are computed
    // from the same pre-edge snapshot, whatever the statement order.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state    <= IDLE;
            a        <= '0;
            w        <= '0;
            oADDR_RD <= '0;
            oRE      <= 1'b0;
            oVALID   <= 1'b0;
            oDONE    <= 1'b0;
            oRDY     <= 1'b1;
        end else begin
            oRE   <= 1'b0;
            oDONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (iSTART) begin
                        state    <= FETCH;
                        a        <= '0;
                        w        <= '0;
                        oADDR_RD <= '0;
                        oRE      <= 1'b1;
                        oRDY     <= 1'b0;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    state  <= STREAM;
                    oVALID <= 1'b1;
                end
                STREAM: begin
                    // oVALID is high for the whole of STREAM, so iREADY alone marks a transfer.
                    if (iREADY) begin
                        if (w == 2'd3) begin
                            w      <= '0;
                            oVALID <= 1'b0;
                            if (a == A_LAST) begin
                                state <= DONE;
                                oDONE <= 1'b1;
                            end else begin
                                state    <= FETCH;
                                a        <= a + `A_BIT'(1);
                                oADDR_RD <= a + `A_BIT'(1);
                                oRE      <= 1'b1;
                            end
                        end else begin
                            w <= w + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    oRDY  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fht_unload_buf u_buf (
        .clk   (iCLK),
        .rst_n (iRESET),
        .load  (state == WAIT),
        .sel   (w),
        .din_0 (iDATA_0),
        .din_1 (iDATA_1),
        .din_2 (iDATA_2),
        .din_3 (iDATA_3),
        .dout  (buf_word)
    );

`ifdef FHT_UNLOAD_SCALE_EN
    logic signed [`D_BIT-1:0] buf_word_s;
    assign buf_word_s = buf_word;
    assign oDATA      = buf_word_s >>> SCALE_SH;
`else
    assign oDATA = buf_word;
`endif

endmodule

// File: tb/tb_fht_unload.sv
// Scoreboard bench for fht_unload: bank model with 1-cycle latency, expected samples
// queued when a start is issued and compared on every stream transfer.
`ifndef A_BIT
`define A_BIT 8
`endif
`ifndef D_BIT
`define D_BIT 16
`endif
`ifndef BANK_SIZE
`define BANK_SIZE (2**`A_BIT)
`endif

module tb_fht_unload;

    localparam int NS    = 1024;
    localparam int TB_SH = 10;

    logic              iCLK = 1'b0;
    logic              iRESET = 1'b0;
    logic              iSTART = 1'b0;
    logic              iREADY = 1'b0;
    logic [`A_BIT-1:0] oADDR_RD;
    logic              oRE, oVALID, oRDY, oDONE;
    logic [`D_BIT-1:0] oDATA;
    logic [`D_BIT-1:0] bank_q [4];

    logic              special = 1'b0;
    int                n_vec = 0;
    int                n_err = 0;
    logic [`D_BIT-1:0] q [$];
    logic [`A_BIT-1:0] exp_addr;
    int                re_cnt, xfer_cnt, done_cnt;

    fht_unload dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iSTART   (iSTART),
        .oADDR_RD (oADDR_RD),
        .oRE      (oRE),
        .iDATA_0  (bank_q[0]),
        .iDATA_1  (bank_q[1]),
        .iDATA_2  (bank_q[2]),
        .iDATA_3  (bank_q[3]),
        .oDATA    (oDATA),
        .oVALID   (oVALID),
        .iREADY   (iREADY),
        .oRDY     (oRDY),
        .oDONE    (oDONE)
    );

    initial forever #5 iCLK = ~iCLK;

    function automatic int sample_value(input int n);
        if (special && n == 0) return -1024;
        if (special && n == 1) return 1023;
        return n;
    endfunction

    function automatic logic [`D_BIT-1:0] expv(input int v);
        logic signed [`D_BIT-1:0] s;
        s = `D_BIT'(v);
`ifdef FHT_UNLOAD_SCALE_EN
        s = s >>> TB_SH;
`endif
        return s;
    endfunction

    always @(posedge iCLK)
        if (oRE)
            for (int k = 0; k < 4; k++)
                bank_q[k] <= `D_BIT'(sample_value(4 * int'(oADDR_RD) + k));

    task automatic monitor();
        logic [`D_BIT-1:0] e;
        forever begin
            @(negedge iCLK);
            if (iRESET) begin
                if (iSTART && oRDY) begin
                    q.delete();
                    for (int n = 0; n < NS; n++) q.push_back(expv(sample_value(n)));
                    exp_addr = '0; re_cnt = 0; xfer_cnt = 0; done_cnt = 0;
                end
                if (oRE) begin
                    n_vec++;
                    if (oADDR_RD !== exp_addr) begin
                        n_err++;
                        $display("FAIL rd_addr: got %0d, want %0d", oADDR_RD, exp_addr);
                    end
                    exp_addr++;
                    re_cnt++;
                end
                if (oVALID && iREADY) begin
                    n_vec++;
                    if (q.size() == 0) begin
                        n_err++;
                        $display("FAIL extra_sample: got %0d, want none", oDATA);
                    end else begin
                        e = q.pop_front();
                        if (oDATA !== e) begin
                            n_err++;
                            $display("FAIL sample[%0d]: got %0d, want %0d", xfer_cnt, oDATA, e);
                        end
                    end
                    xfer_cnt++;
                end
                if (oDONE) begin
                    done_cnt++;
                    n_vec++;
                    if (q.size() != 0) begin
                        n_err++;
                        $display("FAIL done_early: %0d samples outstanding, want 0", q.size());
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        #12;
        chk("rst_rdy", 32'(oRDY), 1);
        chk("rst_valid", 32'(oVALID), 0);
        chk("rst_re", 32'(oRE), 0);
        chk("rst_done", 32'(oDONE), 0);
        chk("rst_data", 32'(oDATA), 0);
        chk("rst_addr", 32'(oADDR_RD), 0);
        iRESET = 1'b1;
        @(posedge iCLK); #1;
    endtask

    task automatic start_unload();
        int t = 0;
        while (!oRDY && t < 100) begin @(posedge iCLK); #1; t++; end
        chk("rdy_before_start", 32'(oRDY), 1);
        iSTART = 1'b1;
        @(posedge iCLK); #1;
        iSTART = 1'b0;
        chk("fetch_re", 32'(oRE), 1);
        chk("fetch_rdy", 32'(oRDY), 0);
        @(posedge iCLK); #1;
        chk("wait_valid", 32'(oVALID), 0);
        chk("wait_re", 32'(oRE), 0);
        @(posedge iCLK); #1;
        chk("first_valid_latency", 32'(oVALID), 1);
    endtask

    task automatic wait_xfer(input int n);
        int t = 0;
        while (!(xfer_cnt == n && oVALID) && t < 4000) begin @(posedge iCLK); #1; t++; end
        chk("reach_sample", 32'(xfer_cnt), 32'(n));
    endtask

    task automatic wait_done();
        int t = 0;
        while (!oDONE && t < 3000) begin @(negedge iCLK); t++; end
        chk("done_seen", 32'(oDONE), 1);
        chk("done_valid", 32'(oVALID), 0);
        chk("done_rdy", 32'(oRDY), 0);
        @(negedge iCLK);
        chk("rdy_after_done", 32'(oRDY), 1);
        chk("done_one_cycle", 32'(oDONE), 0);
        chk("done_count", 32'(done_cnt), 1);
        chk("all_samples", 32'(xfer_cnt), NS);
        chk("re_count", 32'(re_cnt), `BANK_SIZE);
        @(posedge iCLK); #1;
    endtask

    task automatic test_stream();
        iREADY = 1'b1;
        start_unload();
        wait_done();
    endtask

    task automatic test_stall();
        iREADY = 1'b1;
        start_unload();
        wait_xfer(2);
        iREADY = 1'b0;
        repeat (5) begin
            @(posedge iCLK); #1;
            chk("stall_data", 32'(oDATA), 32'(expv(2)));
            chk("stall_valid", 32'(oVALID), 1);
        end
        chk("stall_no_xfer", 32'(xfer_cnt), 2);
        iREADY = 1'b1;
        wait_done();
    endtask

    task automatic test_restart_ignored();
        iREADY = 1'b1;
        start_unload();
        wait_xfer(100);
        iSTART = 1'b1;
        @(posedge iCLK); #1;
        iSTART = 1'b0;
        chk("restart_no_re", 32'(oRE), 0);
        wait_done();
        repeat (20) @(posedge iCLK);
        #1;
        chk("single_done", 32'(done_cnt), 1);
    endtask

    task automatic test_reset_mid();
        iREADY = 1'b1;
        start_unload();
        wait_xfer(300);
        iRESET = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(oRDY), 1);
        chk("mid_rst_valid", 32'(oVALID), 0);
        chk("mid_rst_re", 32'(oRE), 0);
        chk("mid_rst_done", 32'(oDONE), 0);
        chk("mid_rst_data", 32'(oDATA), 0);
        chk("mid_rst_addr", 32'(oADDR_RD), 0);
        repeat (2) @(posedge iCLK);
        #1;
        iRESET = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        chk("mid_rst_no_done", 32'(done_cnt), 0);
        start_unload();
        wait_done();
    endtask

    task automatic test_scale();
        logic [`D_BIT-1:0] want0, want1;
`ifdef FHT_UNLOAD_SCALE_EN
        want0 = '1;
        want1 = '0;
`else
        want0 = `D_BIT'(-1024);
        want1 = `D_BIT'(1023);
`endif
        special = 1'b1;
        iREADY  = 1'b1;
        start_unload();
        chk("scale_s0", 32'(oDATA), 32'(want0));
        @(posedge iCLK); #1;
        chk("scale_s1", 32'(oDATA), 32'(want1));
        wait_done();
        special = 1'b0;
    endtask

    initial begin
        fork
            monitor();
            begin
                test_reset();
                test_stream();
                test_stall();
                test_restart_ignored();
                test_reset_mid();
                test_scale();
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fht_unload.md
FHT_UNLOAD -- requirements
Module: fht_unload

Interface
REQ-001 Parameters: none; widths from shared defines: `A_BIT (bank address bits), `D_BIT (data bits), `BANK_SIZE (words per bank, 2**`A_BIT).
REQ-002 iCLK  in  1  single clock; all logic on rising edge.
REQ-003 iRESET  in  1  asynchronous, active-low reset.
REQ-004 iSTART  in  1  request to unload the four banks after transform completes; level sampled on iCLK.
REQ-005 oADDR_RD  out  `A_BIT  read address, driven identically to banks 0..3.
REQ-006 oRE  out  1  read enable to all four banks.
REQ-007 iDATA_0..iDATA_3  in  `D_BIT each  bank read data, valid exactly 1 cycle after oRE.
REQ-008 oDATA  out  `D_BIT  output sample, two's complement.
REQ-009 oVALID / iREADY  out/in  1  stream handshake; transfer when both high on a rising edge.
REQ-010 oRDY  out  1  high when idle and able to accept iSTART.
REQ-011 oDONE  out  1  one-cycle pulse after final sample transferred.

Function
REQ-012 States: IDLE, FETCH, WAIT, STREAM, DONE.
REQ-013 IDLE: oRDY=1; iSTART=1 -> FETCH, address counter a=0, word index w=0.
REQ-014 FETCH: oRE=1, oADDR_RD=a for exactly one cycle -> WAIT.
REQ-015 WAIT: iDATA_0..3 captured into 4-word buffer at end of cycle -> STREAM.
REQ-016 STREAM: oVALID=1, oDATA=buffer[w]; on transfer w increments; transfer at w=3 with a<`BANK_SIZE-1 -> a+1, w=0, FETCH; with a=`BANK_SIZE-1 -> DONE.
REQ-017 Output order: sample index n=4*a+w, n=0..4*`BANK_SIZE-1, natural order.
REQ-018 oVALID=0 with iREADY=1 produces no transfer; oDATA and w stable while oVALID=1 and iREADY=0, for any stall length.
REQ-019 DONE: oDONE=1 for one cycle, oVALID=0 -> IDLE; oRDY rises the cycle after DONE.
REQ-020 iSTART ignored in every state except IDLE; no restart, no counter disturbance.
REQ-021 iREADY has no effect outside STREAM.
REQ-022 oRE=0 in every state except FETCH; oADDR_RD holds a between fetches.
REQ-023 Throughput: 4 samples per 6 cycles minimum with iREADY held high; first oVALID 2 cycles after iSTART sampled.
REQ-024 Counter a wraps only via DONE path; never exceeds `BANK_SIZE-1.

Reset
REQ-025 iRESET=0 asynchronously forces state IDLE, a=0, w=0, buffer=0, oADDR_RD=0, oRE=0, oDATA=0, oVALID=0, oDONE=0, oRDY=1.
REQ-026 Reset mid-operation aborts unload with no oDONE; next iSTART restarts at n=0.

Configuration
REQ-027 Macro FHT_UNLOAD_SCALE_EN defined: oDATA = buffer[w] arithmetic-shifted right by log2(4*`BANK_SIZE) (sign-extended, truncation toward minus infinity), applied combinationally at output.
REQ-028 Macro undefined: oDATA = buffer[w] unmodified; no shifter present.

Structure
REQ-029 Shared package fht_pkg holds state enum type, constant N_SAMPLES=4*`BANK_SIZE, and constant SCALE_SH=log2(N_SAMPLES).
REQ-030 One sub-module fht_unload_buf: 4x`D_BIT capture register with load strobe and 2-bit read select; FSM, counters, handshake in fht_unload.

Verification
REQ-031 `BANK_SIZE=256, banks model 1-cycle latency with bank k at address a holding 4*a+k; iSTART pulse, iREADY=1 -> oDATA 0,1,...,1023 in order, oDONE one cycle after 1023 transferred, oRDY high next cycle.
REQ-032 Same setup, iREADY low 5 cycles while oDATA=2 -> oDATA held at 2, oVALID held 1, next transfer 3, no sample lost or duplicated.
REQ-033 iSTART pulsed again while streaming sample 100 -> ignored; sequence continues 101..1023, exactly one oDONE.
REQ-034 iRESET low while streaming sample 300 -> all outputs to REQ-025 values immediately; new iSTART -> stream restarts at 0, full 1024 samples.
REQ-035 FHT_UNLOAD_SCALE_EN defined, bank 0 address 0 holds -1024, bank 1 holds 1023 -> oDATA -1 then 0; undefined -> -1024 then 1023.
REQ-036 Check oRE high exactly 256 cycles per unload, each with oADDR_RD equal to prior value +1 starting at 0.
